i2c_master_ctrl: RTL
====================

I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

Interface
REQ-001 SHALL have parameter G_CLK_DIV, default 4, system clocks per SCL quarter-period (legal range 2..255).
REQ-002 SHALL have parameter G_NB_BYTES_W, default 8, width of the byte-count input.
REQ-003 SHALL have port clk  input  1  the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1  one-cycle transfer request, sampled only in IDLE.
REQ-006 SHALL have port rw  input  1  direction: 1 = master read, 0 = master write.
REQ-007 SHALL have port chip_addr  input  7  slave address, sent MSB first.
REQ-008 SHALL have port nb_bytes  input  G_NB_BYTES_W  number of data bytes after the address byte.
REQ-009 SHALL have port wdata  input  8  write byte, sampled on the cycle that wdata_rd is high.
REQ-010 SHALL have port wdata_rd  output  1  one-cycle pulse that consumes wdata.
REQ-011 SHALL have port rdata  output  8  received byte, valid while rdata_valid is high.
REQ-012 SHALL have port rdata_valid  output  1  one-cycle pulse per received byte.
REQ-013 SHALL have port busy  output  1  high from start acceptance until STOP completes.
REQ-014 SHALL have port done  output  1  one-cycle pulse when STOP completes.
REQ-015 SHALL have port ack_error  output  1  slave NACK seen; held until the next accepted start.
REQ-016 SHALL have port sclk  inout  1  open-drain I2C clock: driven 0 or Z.
REQ-017 SHALL have port sda  inout  1  open-drain I2C data: driven 0 or Z.

Function
REQ-018 SHALL drive sclk and sda as open-drain only: a line is 0 when pulled low, otherwise Z; the line is never driven 1.
REQ-019 SHALL use a quarter-tick counter from 0 to G_CLK_DIV-1. Each bit spans phases q0..q3:
  - q0, q1: SCL low; SDA updates at q0 entry.
  - q2, q3: SCL released.
  - SDA is sampled on the last clock of q2.
REQ-020 SHALL implement the FSM IDLE, START, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, STOP.
REQ-021 SHALL handle IDLE as follows:
  - both lines Z, busy=0.
  - start=1 latches rw, chip_addr and nb_bytes, clears ack_error, sets busy on the next cycle and moves to START.
REQ-022 SHALL generate START as follows:
  - SDA Z, SCL Z for q0-q1.
  - SDA 0 for q2-q3.
  - then ADDR.
REQ-023 SHALL shift out {chip_addr, rw} over 8 bit periods in ADDR, MSB first.
REQ-024 SHALL handle ADDR_ACK as follows:
  - release SDA and sample it.
  - 0 (ACK): go to WR_BYTE or RD_BYTE per rw, or to STOP if nb_bytes=0.
  - 1 (NACK): set ack_error and go to STOP.
REQ-025 SHALL pulse wdata_rd at WR_BYTE entry, load wdata into the shift register, and shift it out MSB first.
REQ-026 SHALL handle WR_ACK as follows:
  - NACK: set ack_error, go to STOP.
  - ACK with bytes remaining: go to WR_BYTE.
  - ACK on the last byte: go to STOP.
REQ-027 SHALL handle RD_BYTE as follows:
  - release SDA and shift in 8 samples, MSB first.
  - pulse rdata_valid with rdata on the clock after the 8th sample.
REQ-028 SHALL drive RD_ACK as ACK (SDA 0) for every byte except the last, and NACK (SDA Z) for the last; after the last byte, go to STOP.
REQ-029 SHALL generate STOP as follows:
  - q0: SCL 0, SDA 0.
  - q1: SCL Z.
  - q2-q3: SDA Z.
  - then return to IDLE with done=1 for one cycle and busy=0.
REQ-030 SHALL count bytes with a G_NB_BYTES_W counter; nb_bytes = 2^G_NB_BYTES_W-1 transfers all bytes with no wrap-around.
REQ-031 SHALL ignore start while busy=1; a start in the same cycle as done is ignored.
REQ-032 SHALL make SDA changes only while SCL is low, except for START and STOP edges.
REQ-033 SHALL not stretch or sense the clock; SCL timing is free-running relative to the slave.

Reset
REQ-034 SHALL apply the following on any rising clk with rst_n=0, including mid-transfer:
  - FSM goes to IDLE; counters clear; sclk and sda go Z.
  - busy, done, wdata_rd, rdata_valid and ack_error go to 0; rdata goes to 0x00.
REQ-035 SHALL emit no START/STOP framing on reset; releasing the lines on a mid-transfer reset is acceptable.

Verification
REQ-036 Write, chip_addr=0x50, nb_bytes=2, wdata 0xA5 then 0x3C, slave ACKs -> bus carries 0xA0,0xA5,0x3C with START/STOP; exactly two wdata_rd pulses; done=1 once; ack_error=0.
REQ-037 Read, chip_addr=0x50, nb_bytes=3, slave returns 0x11,0x22,0x33 -> address byte 0xA1; rdata_valid pulses with 0x11, 0x22, 0x33; master ACK, ACK, NACK; STOP.
REQ-038 Address NACK (no slave at 0x12) -> ack_error=1 after ADDR_ACK; no wdata_rd or rdata_valid; STOP issued; done=1.
REQ-039 nb_bytes=0 write -> START, address byte, ACK, STOP only; zero wdata_rd pulses.
REQ-040 rst_n=0 for 1 clock during the 4th data bit of a write -> next cycle sclk=Z, sda=Z, busy=0; a new start after reset completes a normal transfer.
REQ-041 Check against the team I2C slave model, and check SCL period = 4*G_CLK_DIV clocks for G_CLK_DIV=2 and G_CLK_DIV=10.

Source files
------------

// File: rtl/i2c_master_ctrl.sv
// Single-master I2C controller: START, 7-bit address + R/W, N data bytes, STOP.
// Open-drain sclk/sda; one bit = four quarter phases of G_CLK_DIV clocks each.
module i2c_master_ctrl #(
  parameter int G_CLK_DIV    = 4,
  parameter int G_NB_BYTES_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    rw,
  input  logic [6:0]              chip_addr,
  input  logic [G_NB_BYTES_W-1:0] nb_bytes,
  input  logic [7:0]              wdata,
  output logic                    wdata_rd,
  output logic [7:0]              rdata,
  output logic                    rdata_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    ack_error,
  inout  wire                     sclk,
  inout  wire                     sda
);

  localparam int QW = (G_CLK_DIV > 2) ? $clog2(G_CLK_DIV) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WR_BYTE,
    S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_STOP
  } state_t;

  state_t                  state;
  logic [QW-1:0]           qcnt;
  logic [1:0]              phase;
  logic [2:0]              bit_cnt;
  logic [7:0]              shreg;
  logic [G_NB_BYTES_W-1:0] rem;
  logic [6:0]              addr_q;
  logic                    rw_q;
  logic                    sda_smp;
  logic                    scl_lo, sda_pre, sda_lo;
  logic                    scl_nxt, sda_nxt, tx_bit;
  logic                    tick, samp, bit_end, last_byte;

  assign tick      = (qcnt == QW'(G_CLK_DIV - 1));
  assign samp      = tick && (phase == 2'd2);
  assign bit_end   = tick && (phase == 2'd3);
  assign last_byte = (rem == G_NB_BYTES_W'(1));
  assign tx_bit    = (state == S_WR_BYTE && wdata_rd) ? wdata[7] : shreg[7];

  assign sclk = scl_lo ? 1'b0 : 1'bz;
  assign sda  = sda_lo ? 1'b0 : 1'bz;

  // Line levels per state/phase; SDA gets one extra register so it always
  // moves a clock after SCL falls and never races the SCL edge.
  always_comb begin
    scl_nxt = 1'b0;
    sda_nxt = 1'b0;
    case (state)
      S_START:                         sda_nxt = phase[1];
      S_ADDR, S_WR_BYTE: begin
        scl_nxt = ~phase[1];
        sda_nxt = ~tx_bit;
      end
      S_ADDR_ACK, S_WR_ACK, S_RD_BYTE: scl_nxt = ~phase[1];
      S_RD_ACK: begin
        scl_nxt = ~phase[1];
        sda_nxt = ~last_byte;
      end
      S_STOP: begin
        scl_nxt = (phase == 2'd0);
        sda_nxt = ~phase[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      qcnt        <= '0;
      phase       <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      rem         <= '0;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      sda_smp     <= 1'b1;
      scl_lo      <= 1'b0;
      sda_pre     <= 1'b0;
      sda_lo      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      wdata_rd    <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      ack_error   <= 1'b0;
    end else begin
      wdata_rd    <= 1'b0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      scl_lo      <= scl_nxt;
      sda_pre     <= sda_nxt;
      sda_lo      <= sda_pre;
      if (state != S_IDLE) begin
        qcnt <= tick ? '0 : qcnt + 1'b1;
        if (tick) phase <= phase + 2'd1;
      end
      if (samp) sda_smp <= sda;
      if (state == S_WR_BYTE && wdata_rd) shreg <= wdata;

      case (state)
        S_IDLE: begin
          // done high means STOP just finished; a start in that cycle is dropped
          if (start && !done) begin
            rw_q      <= rw;
            addr_q    <= chip_addr;
            rem       <= nb_bytes;
            ack_error <= 1'b0;
            busy      <= 1'b1;
            qcnt      <= '0;
            phase     <= '0;
            state     <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            shreg   <= {addr_q, rw_q};
            bit_cnt <= '0;
            state   <= S_ADDR;
          end
        end
        S_ADDR, S_WR_BYTE: begin
          if (bit_end) begin
            shreg   <= {shreg[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
              state <= (state == S_ADDR) ? S_ADDR_ACK : S_WR_ACK;
          end
        end
        S_ADDR_ACK: begin
          if (bit_end) begin
            if (sda_smp) begin
              ack_error <= 1'b1;
              state     <= S_STOP;
            end else if (rem == '0) begin
              state <= S_STOP;
            end else if (rw_q) begin
              state <= S_RD_BYTE;
            end else begin
              wdata_rd <= 1'b1;
              state    <= S_WR_BYTE;
            end
          end
        end
        S_WR_ACK: begin
          if (bit_end) begin
            if (sda_smp) begin
              ack_error <= 1'b1;
              state     <= S_STOP;
            end else if (last_byte) begin
              state <= S_STOP;
            end else begin
              rem      <= rem - 1'b1;
              wdata_rd <= 1'b1;
              state    <= S_WR_BYTE;
            end
          end
        end
        S_RD_BYTE: begin
          if (samp) begin
            shreg <= {shreg[6:0], sda};
            if (bit_cnt == 3'd7) begin
              rdata       <= {shreg[6:0], sda};
              rdata_valid <= 1'b1;
            end
          end
          if (bit_end) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= S_RD_ACK;
          end
        end
        S_RD_ACK: begin
          if (bit_end) begin
            if (last_byte) begin
              state <= S_STOP;
            end else begin
              rem   <= rem - 1'b1;
              state <= S_RD_BYTE;
            end
          end
        end
        S_STOP: begin
          if (bit_end) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
